// File: rtl/rx_tx_pkg.sv
// Constants, state encoding and CRC-32 byte step shared by the GMII transmit and receive MACs.
package rx_tx_pkg;

  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned PREAMBLE_LEN  = 7;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSfd,
    StData,
    StPad,
    StFcs,
    StDrain,
    StIfg
  } tx_state_e;

  // Reflected CRC-32 update for one byte, LSB first, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide IEEE 802.3 CRC-32 register with synchronous clear and enable.
module crc32_d8
  import rx_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc32_byte(crc_q, data_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/gmii_tx_mac.sv
// GMII transmit MAC: adds preamble/SFD, pads short frames, appends FCS and enforces the
// inter-frame gap; a stalled source mid-frame aborts the frame with tx_er.
module gmii_tx_mac
  import rx_tx_pkg::*;
#(
  parameter int unsigned IFG_CYCLES    = 12,
  parameter int unsigned MIN_FRAME_LEN = 60
) (
  input  logic                  gmii_tx_clk_i,
  input  logic                  gmii_tx_rst_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  output logic [7:0]            gmii_tx_data_o,
  output logic                  gmii_tx_dv_o,
  output logic                  gmii_tx_er_o,
  output logic                  frame_done_o,
  output logic                  underrun_o
);

  localparam logic [10:0] MinLen    = 11'(MIN_FRAME_LEN);
  // IDLE contributes the final idle cycle before the preamble, so IFG lasts one cycle less.
  // IFG_CYCLES must be at least 2.
  localparam logic [15:0] IfgExit   = 16'(IFG_CYCLES - 2);
  localparam logic [15:0] PreExit   = 16'(PREAMBLE_LEN - 1);

  tx_state_e   state_q;
  logic [10:0] byte_cnt_q;
  logic [15:0] aux_cnt_q;
  logic [7:0]  data_q;
  logic        dv_q, er_q, frame_done_q, underrun_q, last_fcs_q;

  logic [10:0] byte_inc;
  logic [31:0] crc, fcs;
  logic [7:0]  fcs_byte, crc_din;
  logic        crc_en, crc_clr;

  assign byte_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign s_ready_o = (state_q == StData) || (state_q == StDrain);

  assign crc_clr = (state_q == StIdle);
  assign crc_en  = ((state_q == StData) && s_valid_i) || (state_q == StPad);
  assign crc_din = (state_q == StPad) ? 8'h00 : s_data_i;

  crc32_d8 u_crc (
    .clk_i  (gmii_tx_clk_i),
    .rst_i  (gmii_tx_rst_i),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .data_i (crc_din),
    .crc_o  (crc)
  );

  assign fcs      = ~crc;
  assign fcs_byte = fcs[{aux_cnt_q[1:0], 3'b000} +: 8];

  always_ff @(posedge gmii_tx_clk_i or posedge gmii_tx_rst_i) begin
    if (gmii_tx_rst_i) begin
      state_q      <= StIdle;
      byte_cnt_q   <= '0;
      aux_cnt_q    <= '0;
      data_q       <= '0;
      dv_q         <= 1'b0;
      er_q         <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      last_fcs_q   <= 1'b0;
    end else begin
      data_q       <= '0;
      dv_q         <= 1'b0;
      er_q         <= 1'b0;
      underrun_q   <= 1'b0;
      last_fcs_q   <= 1'b0;
      frame_done_q <= last_fcs_q;
      unique case (state_q)
        StIdle: begin
          byte_cnt_q <= '0;
          aux_cnt_q  <= '0;
          if (s_valid_i) state_q <= StPreamble;
        end
        StPreamble: begin
          data_q    <= PREAMBLE_BYTE;
          dv_q      <= 1'b1;
          aux_cnt_q <= aux_cnt_q + 16'd1;
          if (aux_cnt_q == PreExit) begin
            aux_cnt_q <= '0;
            state_q   <= StSfd;
          end
        end
        StSfd: begin
          data_q  <= SFD_BYTE;
          dv_q    <= 1'b1;
          state_q <= StData;
        end
        StData: begin
          dv_q <= 1'b1;
          if (s_valid_i) begin
            data_q     <= s_data_i;
            byte_cnt_q <= byte_inc;
            if (s_last_i) state_q <= (byte_inc < MinLen) ? StPad : StFcs;
          end else begin
            er_q       <= 1'b1;
            underrun_q <= 1'b1;
            state_q    <= StDrain;
          end
        end
        StPad: begin
          dv_q       <= 1'b1;
          byte_cnt_q <= byte_inc;
          if (byte_inc >= MinLen) state_q <= StFcs;
        end
        StFcs: begin
          data_q    <= fcs_byte;
          dv_q      <= 1'b1;
          aux_cnt_q <= aux_cnt_q + 16'd1;
          if (aux_cnt_q[1:0] == 2'd3) begin
            aux_cnt_q  <= '0;
            last_fcs_q <= 1'b1;
            state_q    <= StIfg;
          end
        end
        StDrain: begin
          if (s_valid_i && s_last_i) begin
            aux_cnt_q <= '0;
            state_q   <= StIfg;
          end
        end
        StIfg: begin
          aux_cnt_q <= aux_cnt_q + 16'd1;
          if (aux_cnt_q >= IfgExit) state_q <= StIdle;
        end
      endcase
    end
  end

  assign gmii_tx_data_o = data_q;
  assign gmii_tx_dv_o   = dv_q;
  assign gmii_tx_er_o   = er_q;
  assign frame_done_o   = frame_done_q;
  assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_gmii_tx_mac.sv
// Directed bench for gmii_tx_mac: frame framing, padding, FCS, gap, underrun and reset.
module tb_gmii_tx_mac;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready, dv, er, fd, ur;
  logic [7:0] txd;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       dv;
    logic       er;
    logic       fd;
    logic       ur;
    logic [7:0] d;
  } smp_t;

  smp_t       log_q[$];
  logic [7:0] exp_q[$];
  bit         cap_en = 1'b0;

  gmii_tx_mac #(
    .IFG_CYCLES    (12),
    .MIN_FRAME_LEN (60)
  ) dut (
    .gmii_tx_clk_i  (clk),
    .gmii_tx_rst_i  (rst),
    .s_data_i       (s_data),
    .s_valid_i      (s_valid),
    .s_last_i       (s_last),
    .s_ready_o      (s_ready),
    .gmii_tx_data_o (txd),
    .gmii_tx_dv_o   (dv),
    .gmii_tx_er_o   (er),
    .frame_done_o   (fd),
    .underrun_o     (ur)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (cap_en) log_q.push_back({dv, er, fd, ur, txd});
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pat(input int seed, input int idx);
    return 8'((seed * 31 + idx * 13 + 1) & 255);
  endfunction

  // Bit-serial reference CRC-32 (reflected), no final inversion.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic build_expected(input int len, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    int          tot;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    c   = 32'hFFFFFFFF;
    tot = (len < 60) ? 60 : len;
    for (int i = 0; i < tot; i++) begin
      b = (i < len) ? pat(seed, i) : 8'h00;
      exp_q.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_log();
    log_q.delete();
    cap_en = 1'b1;
  endtask

  function automatic void find_run(input int from, output int st, output int n);
    st = -1;
    n  = 0;
    for (int i = from; i < log_q.size(); i++) begin
      if (log_q[i].dv) begin
        st = i;
        break;
      end
    end
    if (st >= 0) begin
      for (int i = st; i < log_q.size() && log_q[i].dv; i++) n++;
    end
  endfunction

  function automatic int run_bad(input int st, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (st < 0 || st + i >= log_q.size() || i >= exp_q.size()) bad++;
      else if (log_q[st + i].d !== exp_q[i]) bad++;
    end
    return bad;
  endfunction

  function automatic logic [31:0] run_residue(input int st, input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 8; i < n; i++) c = crc_upd(c, log_q[st + i].d);
    return c;
  endfunction

  function automatic int count_fd();
    int k = 0;
    foreach (log_q[i]) if (log_q[i].fd) k++;
    return k;
  endfunction

  function automatic int count_er();
    int k = 0;
    foreach (log_q[i]) if (log_q[i].er) k++;
    return k;
  endfunction

  function automatic int count_ur();
    int k = 0;
    foreach (log_q[i]) if (log_q[i].ur) k++;
    return k;
  endfunction

  function automatic int count_dv();
    int k = 0;
    foreach (log_q[i]) if (log_q[i].dv) k++;
    return k;
  endfunction

  task automatic drive_frame(input int len, input int drop_at, input int stop_at, input int seed,
                             output bit to);
    int idx = 0;
    int cyc = 0;
    int stop;
    bit acc;
    bit dropped = 1'b0;
    stop    = (stop_at >= 0) ? stop_at : len;
    s_valid = 1'b1;
    s_data  = pat(seed, 0);
    s_last  = (len == 1);
    while (idx < stop && cyc < 5000) begin
      if (idx == drop_at && !dropped) begin
        s_valid = 1'b0;
        dropped = 1'b1;
      end
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) idx++;
      s_valid = (idx < len);
      s_data  = pat(seed, idx);
      s_last  = (idx == len - 1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    to      = (idx < stop);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({txd, dv, er, fd, ur, s_ready} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {txd, dv, er, fd, ur, s_ready});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_log();
    wait_cycles(6);
    cap_en = 1'b0;
    checks++;
    if (count_dv() != 0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: dv_cycles=%0d ready=%b want 0/0", count_dv(), s_ready);
    end
  endtask

  task automatic test_frame_60();
    int st, n;
    bit to;
    logic [31:0] res;
    build_expected(60, 1);
    start_log();
    drive_frame(60, -1, -1, 1, to);
    wait_cycles(20);
    cap_en = 1'b0;
    find_run(0, st, n);
    res = run_residue(st, n);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL f60_timeout: got %b want 0", to); end
    checks++;
    if (st != 2) begin errors++; $display("FAIL f60_start: got %0d want 2", st); end
    checks++;
    if (n != 72) begin errors++; $display("FAIL f60_dv_len: got %0d want 72", n); end
    checks++;
    if (run_bad(st, 72) != 0) begin
      errors++;
      $display("FAIL f60_bytes: got %0d bad bytes want 0", run_bad(st, 72));
    end
    checks++;
    if (res !== 32'hDEBB20E3) begin
      errors++;
      $display("FAIL f60_residue: got %h want debb20e3", res);
    end
    checks++;
    if (count_fd() != 1) begin errors++; $display("FAIL f60_done_cnt: got %0d want 1", count_fd()); end
    checks++;
    if (st + n >= log_q.size() || log_q[st + n].fd !== 1'b1) begin
      errors++;
      $display("FAIL f60_done_pos: no frame_done right after last FCS byte, want 1");
    end
    checks++;
    if (count_er() != 0) begin errors++; $display("FAIL f60_er: got %0d want 0", count_er()); end
  endtask

  task automatic test_pad_14();
    int st, n, zeros;
    bit to;
    logic [31:0] res;
    build_expected(14, 2);
    start_log();
    drive_frame(14, -1, -1, 2, to);
    wait_cycles(70);
    cap_en = 1'b0;
    find_run(0, st, n);
    checks++;
    if (to !== 1'b0 || n != 72) begin
      errors++;
      $display("FAIL pad_dv_len: got %0d (timeout=%b) want 72", n, to);
    end
    zeros = 0;
    for (int i = 22; i < 68 && st >= 0 && st + i < log_q.size(); i++) begin
      if (log_q[st + i].d === 8'h00) zeros++;
    end
    checks++;
    if (zeros != 46) begin errors++; $display("FAIL pad_zeros: got %0d want 46", zeros); end
    checks++;
    if (run_bad(st, 72) != 0) begin
      errors++;
      $display("FAIL pad_bytes: got %0d bad bytes want 0", run_bad(st, 72));
    end
    res = (st >= 0 && n == 72) ? run_residue(st, n) : 32'h0;
    checks++;
    if (res !== 32'hDEBB20E3) begin
      errors++;
      $display("FAIL pad_residue: got %h want debb20e3", res);
    end
  endtask

  task automatic test_back_to_back();
    int st1, n1, st2, n2;
    bit to1, to2;
    build_expected(60, 3);
    start_log();
    drive_frame(60, -1, -1, 3, to1);
    drive_frame(60, -1, -1, 3, to2);
    wait_cycles(20);
    cap_en = 1'b0;
    find_run(0, st1, n1);
    find_run(st1 + n1, st2, n2);
    checks++;
    if (to1 || to2 || n1 != 72) begin
      errors++;
      $display("FAIL b2b_len1: got %0d (timeout=%b%b) want 72", n1, to1, to2);
    end
    checks++;
    if (st2 - (st1 + n1) != 12) begin
      errors++;
      $display("FAIL b2b_gap: got %0d idle cycles want 12", st2 - (st1 + n1));
    end
    checks++;
    if (n2 != 72) begin errors++; $display("FAIL b2b_len2: got %0d want 72", n2); end
    checks++;
    if (run_bad(st2, 72) != 0) begin
      errors++;
      $display("FAIL b2b_bytes2: got %0d bad bytes want 0", run_bad(st2, 72));
    end
    checks++;
    if (count_fd() != 2) begin errors++; $display("FAIL b2b_done: got %0d want 2", count_fd()); end
  endtask

  task automatic test_underrun();
    int st, n, st2, n2;
    bit to;
    build_expected(100, 4);
    start_log();
    drive_frame(100, 20, -1, 4, to);
    wait_cycles(20);
    cap_en = 1'b0;
    find_run(0, st, n);
    checks++;
    if (to !== 1'b0 || n != 29) begin
      errors++;
      $display("FAIL ur_dv_len: got %0d (timeout=%b) want 29", n, to);
    end
    checks++;
    if (st < 0 || st + 28 >= log_q.size() || log_q[st + 28].er !== 1'b1 ||
        log_q[st + 28].ur !== 1'b1) begin
      errors++;
      $display("FAIL ur_err_cycle: er/underrun not set on final dv cycle, want 1/1");
    end
    checks++;
    if (count_er() != 1) begin errors++; $display("FAIL ur_er_cnt: got %0d want 1", count_er()); end
    checks++;
    if (count_ur() != 1) begin errors++; $display("FAIL ur_pulse_cnt: got %0d want 1", count_ur()); end
    checks++;
    if (count_dv() != 29) begin
      errors++;
      $display("FAIL ur_no_fcs: got %0d dv cycles want 29", count_dv());
    end
    checks++;
    if (count_fd() != 0) begin errors++; $display("FAIL ur_done: got %0d want 0", count_fd()); end
    checks++;
    if (run_bad(st, 28) != 0) begin
      errors++;
      $display("FAIL ur_bytes: got %0d bad bytes want 0", run_bad(st, 28));
    end
    build_expected(60, 7);
    start_log();
    drive_frame(60, -1, -1, 7, to);
    wait_cycles(20);
    cap_en = 1'b0;
    find_run(0, st2, n2);
    checks++;
    if (to || n2 != 72 || run_bad(st2, 72) != 0) begin
      errors++;
      $display("FAIL ur_next_frame: len=%0d bad=%0d want 72/0", n2, run_bad(st2, 72));
    end
  endtask

  task automatic test_reset_mid();
    int st, n;
    bit to;
    start_log();
    drive_frame(100, -1, 30, 5, to);
    cap_en = 1'b0;
    checks++;
    if (to || dv !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_dv: got dv=%b timeout=%b want 1/0", dv, to);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({txd, dv, er, fd, ur, s_ready} !== 13'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h want 0", {txd, dv, er, fd, ur, s_ready});
    end
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(3);
    checks++;
    if (dv !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_stay_idle: got dv=%b ready=%b want 0/0", dv, s_ready);
    end
    build_expected(60, 5);
    start_log();
    drive_frame(60, -1, -1, 5, to);
    wait_cycles(20);
    cap_en = 1'b0;
    find_run(0, st, n);
    checks++;
    if (st != 2) begin errors++; $display("FAIL rst_no_ifg: got start %0d want 2", st); end
    checks++;
    if (to || n != 72 || run_bad(st, 72) != 0) begin
      errors++;
      $display("FAIL rst_next_frame: len=%0d bad=%0d want 72/0", n, run_bad(st, 72));
    end
  endtask

  task automatic test_long_frame();
    int st, n;
    bit to;
    logic [31:0] res;
    build_expected(1514, 6);
    start_log();
    drive_frame(1514, -1, -1, 6, to);
    wait_cycles(20);
    cap_en = 1'b0;
    find_run(0, st, n);
    checks++;
    if (to || n != 1526) begin
      errors++;
      $display("FAIL long_dv_len: got %0d (timeout=%b) want 1526", n, to);
    end
    checks++;
    if (run_bad(st, 1526) != 0) begin
      errors++;
      $display("FAIL long_bytes: got %0d bad bytes want 0", run_bad(st, 1526));
    end
    res = (st >= 0 && n == 1526) ? run_residue(st, n) : 32'h0;
    checks++;
    if (res !== 32'hDEBB20E3) begin
      errors++;
      $display("FAIL long_residue: got %h want debb20e3", res);
    end
    checks++;
    if (count_fd() != 1) begin errors++; $display("FAIL long_done: got %0d want 1", count_fd()); end
  endtask

  initial begin
    test_reset();
    test_frame_60();
    test_pad_14();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    test_long_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
